// File: rtl/encoder_ctrl.sv
// -----------------------------------------------------------------------------
// encoder_ctrl
// Two-pass sequencer for a circular (tail-biting) convolutional encoder core.
// Pass 1 runs the block from state 0 to find the final state. That state and
// N mod 15 address an external circulation-state lookup. Pass 2 reloads the
// core with the circulation state and re-runs the block, this time flagging
// the core outputs as valid for downstream. A block with N == 0 or
// N mod 15 == 0 has no circulation state and ends with an error.
//
// Ports
//   i_clk, i_rstn        clock, synchronous active-low reset
//   i_start, i_blk_len   start request (sampled in IDLE) and block length N
//   o_busy               high whenever not IDLE
//   o_done, o_err        end-of-block pulse and its error flag
//   o_rd_en, o_rd_addr   couple-memory read strobe / couple index
//   o_core_valid         core input valid (read strobe delayed one cycle)
//   o_core_ena           core enable during both RUN phases
//   o_core_load_si       load o_core_si into the core state register
//   o_core_si            state value to load
//   i_core_so            current core state
//   o_csl_idx            circulation lookup address: N mod 15
//   o_csl_state          circulation lookup address: pass-1 final state
//   i_csl_sc             circulation state from the lookup (combinational)
//   o_out_valid          core outputs valid for downstream (pass 2 only)
//   o_out_idx            couple index of the valid core outputs
// -----------------------------------------------------------------------------
module encoder_ctrl #(
   parameter int MAX_BLOCK_WIDTH = 10
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_start,
   input  logic [MAX_BLOCK_WIDTH-1:0] i_blk_len,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err,
   output logic                       o_rd_en,
   output logic [MAX_BLOCK_WIDTH-1:0] o_rd_addr,
   output logic                       o_core_valid,
   output logic                       o_core_ena,
   output logic                       o_core_load_si,
   output logic [3:0]                 o_core_si,
   input  logic [3:0]                 i_core_so,
   output logic [3:0]                 o_csl_idx,
   output logic [3:0]                 o_csl_state,
   input  logic [3:0]                 i_csl_sc,
   output logic                       o_out_valid,
   output logic [MAX_BLOCK_WIDTH-1:0] o_out_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_P1_LOAD,
      S_P1_RUN,
      S_P1_END,
      S_P2_LOAD,
      S_P2_RUN,
      S_DONE
   } state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic [MAX_BLOCK_WIDTH-1:0] r_n;       // captured block length
   logic [MAX_BLOCK_WIDTH-1:0] r_cnt;     // couples issued in current pass, 0..N
   logic [3:0]                 r_mod15;   // pass-1 valid count modulo 15
   logic [3:0]                 r_sc;      // circulation state for pass 2
   logic                       r_valid;   // read strobe delayed to match memory
   logic [MAX_BLOCK_WIDTH-1:0] r_vidx;    // couple index delayed with r_valid
   logic                       r_err;

   logic                       w_run;
   logic                       w_rd_en;

   // r_cnt stops at N, so the read window is the first N cycles of a RUN
   // state and the extra cycle lets the last delayed valid drain.
   assign w_run   = (r_state == S_P1_RUN) || (r_state == S_P2_RUN);
   assign w_rd_en = w_run && (r_cnt < r_n);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: assign a default before the case so every path drives w_next;
      // a path that leaves it unassigned would infer a latch.
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next = (i_blk_len == '0) ? S_DONE : S_P1_LOAD;
            end
         end
         S_P1_LOAD: w_next = S_P1_RUN;
         S_P1_RUN:  if (r_cnt == r_n) w_next = S_P1_END;
         S_P1_END:  w_next = (r_mod15 == 4'd0) ? S_DONE : S_P2_LOAD;
         S_P2_LOAD: w_next = S_P2_RUN;
         S_P2_RUN:  if (r_cnt == r_n) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!i_rstn) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_cnt   <= '0;
         r_mod15 <= 4'd0;
         r_sc    <= 4'd0;
         r_valid <= 1'b0;
         r_vidx  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_valid <= w_rd_en;
         r_vidx  <= w_rd_en ? r_cnt : '0;

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_n   <= i_blk_len;
                  r_err <= (i_blk_len == '0);
               end
            end
            S_P1_LOAD: begin
               r_cnt   <= '0;
               r_mod15 <= 4'd0;
            end
            S_P1_RUN: begin
               if (r_cnt < r_n) r_cnt <= r_cnt + 1'b1;
               if (r_valid) r_mod15 <= (r_mod15 == 4'd14) ? 4'd0 : r_mod15 + 4'd1;
            end
            S_P1_END: begin
               // A zero residue means N is a multiple of 15: no circulation state.
               r_sc  <= i_csl_sc;
               r_err <= (r_mod15 == 4'd0);
            end
            S_P2_LOAD: r_cnt <= '0;
            S_P2_RUN:  if (r_cnt < r_n) r_cnt <= r_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registered state so they are all 0 right after reset
   // ---------------------------------------------------------------------------
   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = (r_state == S_DONE);
   assign o_err          = (r_state == S_DONE) && r_err;
   assign o_rd_en        = w_rd_en;
   assign o_rd_addr      = w_rd_en ? r_cnt : '0;
   assign o_core_valid   = r_valid && w_run;
   assign o_core_ena     = w_run;
   assign o_core_load_si = (r_state == S_P1_LOAD) || (r_state == S_P2_LOAD);
   assign o_core_si      = (r_state == S_P2_LOAD) ? r_sc : 4'd0;
   assign o_csl_idx      = (r_state == S_P1_END) ? r_mod15 : 4'd0;
   assign o_csl_state    = (r_state == S_P1_END) ? i_core_so : 4'd0;
   assign o_out_valid    = r_valid && (r_state == S_P2_RUN);
   assign o_out_idx      = o_out_valid ? r_vidx : '0;

endmodule

// File: tb/tb_encoder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_encoder_ctrl
// Directed bench for encoder_ctrl. Supplies a couple memory, a 4-bit linear
// core model whose state transition matrix has order 15, and a circulation
// lookup derived from that model. Cycle numbers count from the cycle after the
// edge that accepts i_start (that cycle is cycle 0).
// -----------------------------------------------------------------------------
module tb_encoder_ctrl;

   localparam int W = 10;

   logic         clk;
   logic         rstn;
   logic         i_start;
   logic [W-1:0] i_blk_len;
   logic         o_busy, o_done, o_err, o_rd_en;
   logic [W-1:0] o_rd_addr;
   logic         o_core_valid, o_core_ena, o_core_load_si;
   logic [3:0]   o_core_si, i_core_so, o_csl_idx, o_csl_state, i_csl_sc;
   logic         o_out_valid;
   logic [W-1:0] o_out_idx;

   int n_pass;
   int n_total;

   logic         mem_a [0:(1<<W)-1];
   logic         mem_b [0:(1<<W)-1];
   logic         a_q, b_q;
   logic [3:0]   core_s;

   encoder_ctrl #(.MAX_BLOCK_WIDTH(W)) dut (
      .i_clk          (clk),
      .i_rstn         (rstn),
      .i_start        (i_start),
      .i_blk_len      (i_blk_len),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_err          (o_err),
      .o_rd_en        (o_rd_en),
      .o_rd_addr      (o_rd_addr),
      .o_core_valid   (o_core_valid),
      .o_core_ena     (o_core_ena),
      .o_core_load_si (o_core_load_si),
      .o_core_si      (o_core_si),
      .i_core_so      (i_core_so),
      .o_csl_idx      (o_csl_idx),
      .o_csl_state    (o_csl_state),
      .i_csl_sc       (i_csl_sc),
      .o_out_valid    (o_out_valid),
      .o_out_idx      (o_out_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core state step: multiply by x modulo x^4+x+1 (order 15), inject couple.
   function automatic logic [3:0] step(input logic [3:0] s, input logic a, input logic b);
      logic [3:0] t;
      t = {s[2:0], 1'b0} ^ (s[3] ? 4'b0011 : 4'b0000);
      return t ^ {2'b00, b, a};
   endfunction

   function automatic logic [3:0] apow(input logic [3:0] s, input int k);
      logic [3:0] t;
      t = s;
      for (int i = 0; i < k; i++) t = step(t, 1'b0, 1'b0);
      return t;
   endfunction

   // Circulation state Sc solves Sc = A^k*Sc + S  (k = N mod 15).
   function automatic logic [3:0] lut(input logic [3:0] k, input logic [3:0] s);
      logic [3:0] x;
      for (int i = 0; i < 16; i++) begin
         x = 4'(i);
         if ((apow(x, int'(k)) ^ x) == s) return x;
      end
      return 4'd0;
   endfunction

   assign i_csl_sc  = lut(o_csl_idx, o_csl_state);
   assign i_core_so = core_s;

   // Couple memory (one-cycle read latency) and encoder core model.
   always @(posedge clk) begin
      if (o_rd_en) begin
         a_q <= mem_a[o_rd_addr];
         b_q <= mem_b[o_rd_addr];
      end
      if (!rstn)               core_s <= 4'd0;
      else if (o_core_load_si) core_s <= o_core_si;
      else if (o_core_valid)   core_s <= step(core_s, a_q, b_q);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic start_block(input int n);
      @(negedge clk);
      i_blk_len = W'(n);
      i_start   = 1'b1;
   endtask

   // Watch one block from cycle 0 until o_done, then compare against the model.
   task automatic monitor(input int n, input bit hold, input string tag);
      int         rd_cnt, load_cnt, out_cnt, idx_bad, stray, done_rel;
      logic       err_seen;
      logic [3:0] p1si, si2, csl_i, csl_s, fin, s1, sc;
      bit         legal;
      rd_cnt = 0; load_cnt = 0; out_cnt = 0; idx_bad = 0; stray = 0;
      done_rel = -1; err_seen = 1'b0;
      p1si = 4'hf; si2 = 4'hf; csl_i = 4'hf; csl_s = 4'hf; fin = 4'hf;
      s1 = 4'd0;
      for (int i = 0; i < n; i++) s1 = step(s1, mem_a[i], mem_b[i]);
      sc = lut(4'(n % 15), s1);
      legal = (n != 0) && (n % 15 != 0);

      for (int rel = 0; rel < 2 * n + 20; rel++) begin
         @(negedge clk);
         if (rel == 0 && !hold) i_start = 1'b0;
         if (o_rd_en) rd_cnt++;
         if (o_core_load_si) begin
            if (load_cnt == 0) p1si = o_core_si;
            else               si2  = o_core_si;
            load_cnt++;
         end
         if (o_out_valid) begin
            if (int'(o_out_idx) != out_cnt) idx_bad++;
            out_cnt++;
         end
         if ((o_core_valid || o_out_valid) && !o_core_ena) stray++;
         if (o_busy && !o_core_ena && !o_core_load_si && !o_done) begin
            csl_i = o_csl_idx;
            csl_s = o_csl_state;
         end
         if (o_done) begin
            done_rel = rel;
            err_seen = o_err;
            fin      = core_s;
            break;
         end
      end

      check({tag, " done_cycle"}, 64'(done_rel),
            64'((n == 0) ? 0 : (legal ? 2 * n + 5 : n + 3)));
      check({tag, " err"}, 64'(err_seen), 64'(!legal));
      check({tag, " rd_count"}, 64'(rd_cnt), 64'((n == 0) ? 0 : (legal ? 2 * n : n)));
      check({tag, " load_count"}, 64'(load_cnt), 64'((n == 0) ? 0 : (legal ? 2 : 1)));
      check({tag, " out_count"}, 64'(out_cnt), 64'(legal ? n : 0));
      check({tag, " out_idx_order"}, 64'(idx_bad), 64'd0);
      check({tag, " valid_outside_run"}, 64'(stray), 64'd0);
      if (n != 0) begin
         check({tag, " p1_si"}, 64'(p1si), 64'd0);
         check({tag, " csl_idx"}, 64'(csl_i), 64'(n % 15));
         check({tag, " csl_state"}, 64'(csl_s), 64'(s1));
      end
      if (legal) begin
         check({tag, " p2_si"}, 64'(si2), 64'(sc));
         check({tag, " final_state"}, 64'(fin), 64'(sc));
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({o_busy, o_done, o_err, o_rd_en, o_rd_addr, o_core_valid, o_core_ena,
                  o_core_load_si, o_core_si, o_csl_idx, o_csl_state, o_out_valid, o_out_idx});
   endfunction

   function automatic void fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         mem_a[i] = 1'($urandom_range(0, 1));
         mem_b[i] = 1'($urandom_range(0, 1));
      end
   endfunction

   initial begin
      int out_seen;
      bit done_seen;
      n_pass = 0; n_total = 0;
      rstn = 1'b0; i_start = 1'b0; i_blk_len = '0;
      a_q = 1'b0; b_q = 1'b0;
      for (int i = 0; i < (1 << W); i++) begin
         mem_a[i] = 1'b0;
         mem_b[i] = 1'b0;
      end

      repeat (3) @(negedge clk);
      check("reset outputs", all_outs(), 64'd0);
      rstn = 1'b1;

      // N=1, couple (a=1,b=0)
      mem_a[0] = 1'b1; mem_b[0] = 1'b0;
      start_block(1);
      monitor(1, 1'b0, "n1");

      // N=15: illegal multiple of 15, detected after pass 1
      fill_random(15);
      start_block(15);
      monitor(15, 1'b0, "n15");

      // N=0: illegal, immediate error
      start_block(0);
      monitor(0, 1'b0, "n0");

      // N=16: first legal length past a multiple of 15
      fill_random(16);
      start_block(16);
      monitor(16, 1'b0, "n16");

      // N=48: random couples, counter wraps several times
      fill_random(48);
      start_block(48);
      monitor(48, 1'b0, "n48");

      // Reset in the middle of pass 2 of N=100
      fill_random(100);
      start_block(100);
      out_seen = 0; done_seen = 1'b0;
      for (int i = 0; i < 300 && out_seen < 10; i++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (o_out_valid) out_seen++;
         if (o_done) done_seen = 1'b1;
      end
      check("abort reached p2", 64'(out_seen), 64'd10);
      rstn = 1'b0;
      @(negedge clk);
      check("abort outputs zero", all_outs(), 64'd0);
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (o_done) done_seen = 1'b1;
      end
      check("abort no done", 64'(done_seen), 64'd0);
      fill_random(2);
      start_block(2);
      monitor(2, 1'b0, "n2_after_rst");

      // i_start held high: second block only starts from IDLE after o_done
      fill_random(3);
      start_block(3);
      monitor(3, 1'b1, "hold_blk1");
      @(negedge clk);
      check("hold idle gap busy", 64'(o_busy), 64'd0);
      monitor(3, 1'b0, "hold_blk2");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
